mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Sits directly upstream of the single-port word memory and is its only master.
//   Arbitrates between two requesters each cycle:
//     - instruction fetch (IF): read-only
//     - data port (DM): load/store
//   Drives the memory's mode/address/data_in and returns read data with valid/ready handshakes.
//   Tracks the memory's 1-cycle registered read latency and holds a response while the consumer stalls.
// PARAMETERS
//   STARVE_LIMIT  3      consecutive DM grants while IF waits before IF is forced; 0 = DM strict priority
//   MODE_IDLE     2'b11  mem_mode value for no access; must differ from `memModeIn and `memModeOut
// PORTS
//   clk           in   1   clock; all state updates on posedge
//   reset         in   1   synchronous, active-high
//   if_req_valid  in   1   fetch read request
//   if_req_ready  out  1   fetch request accepted this cycle
//   if_addr       in   16  fetch address
//   if_rsp_valid  out  1   fetch read data valid
//   if_rsp_data   out  16  fetch read data
//   if_rsp_ready  in   1   fetch consumer accepts response
//   dm_req_valid  in   1   data request
//   dm_req_write  in   1   1 = store, 0 = load
//   dm_req_ready  out  1   data request accepted this cycle
//   dm_addr       in   16  data address
//   dm_wdata      in   16  store data
//   dm_rsp_valid  out  1   load data valid (never raised for stores)
//   dm_rsp_data   out  16  load data
//   dm_rsp_ready  in   1   data consumer accepts response
//   mem_mode      out  2   `memModeOut (read), `memModeIn (write) or MODE_IDLE
//   mem_addr      out  16  memory address
//   mem_wdata     out  16  memory data_in
//   mem_rdata     in   16  memory data_out
// BEHAVIOUR
//   - Reset
//       - state S_IDLE; rsp_valids 0; starve_cnt 0; hold register 0.
//       - Comb outputs reset-consistent in the first cycle after reset: ready 0, mem_mode MODE_IDLE.
//       - Reset during a pending read drops the response; no rsp_valid follows.
//   - Accept = req_valid & req_ready.
//       - req_ready is combinational from the grant; at most one of if_req_ready/dm_req_ready is high.
//   - Grant (comb)
//       - None if state==S_HOLD, or if state==S_READ and the current owner's rsp_ready==0.
//       - Otherwise IF when STARVE_LIMIT!=0 && starve_cnt==STARVE_LIMIT && if_req_valid.
//       - Else DM if dm_req_valid, else IF if if_req_valid.
//   - mem_mode/mem_addr/mem_wdata are comb from the granted request in the accept cycle.
//       - mem_mode is MODE_IDLE when nothing is granted.
//       - mem_wdata = dm_wdata on store, else 0.
//   - Read latency is 1: a read accepted in cycle N gives owner rsp_valid=1 in N+1, data = mem_rdata.
//   - A store completes on the accept edge and produces no response.
//   - States (registered owner flag IF/DM):
//       - S_IDLE: no response outstanding. Read accept -> S_READ; store/none -> S_IDLE.
//       - S_READ: response presented from mem_rdata.
//           - owner rsp_ready=1: response retires; a new grant is allowed the same cycle.
//             New read -> S_READ (owner updated); else -> S_IDLE.
//           - owner rsp_ready=0: capture mem_rdata into the hold register -> S_HOLD.
//       - S_HOLD: rsp_data driven from the hold register, stable, rsp_valid held at 1.
//           - No grants; mem_mode MODE_IDLE.
//           - Owner rsp_ready=1 -> S_IDLE.
//   - Non-owner rsp_valid is 0; non-owner rsp_data is 0.
//   - Starvation counter starve_cnt:
//       - DM grant with if_req_valid=1: +1, saturating at STARVE_LIMIT.
//       - IF grant, or if_req_valid=0: cleared to 0.
//   - Addresses use the full 16 bits; 0xFFFF is legal and there is no wrap logic.
//   - Simultaneous IF/DM requests to the same address: the grant order above decides.
//     A store granted first is visible to a later read.
// CONFIGURATION
//   MEM_ARB_STATS_EN defined:
//     - adds outputs stall_cycles[15:0] and dm_forced_yield[15:0]; both cleared by reset.
//     - stall_cycles: +1 per cycle any req_valid is high with no accept; saturates at 0xFFFF.
//     - dm_forced_yield: +1 per starvation-forced IF grant; saturates at 0xFFFF.
//   MEM_ARB_STATS_EN undefined: ports and counters absent; remaining behaviour identical.
// TESTING
//   1 mem[0x0010]=0x1234, IF read 0x0010 in cycle 1 -> cycle 1 mem_mode=`memModeOut,
//     cycle 2 if_rsp_valid=1, if_rsp_data=0x1234.
//   2 IF and DM load valid every cycle, rsp_ready=1, STARVE_LIMIT=3 -> grants D,D,D,I,D,D,D,I.
//   3 DM store 0xBEEF to 0xFFFF, then DM load 0xFFFF -> no rsp for store;
//     load rsp_data=0xBEEF one cycle after accept.
//   4 Back-to-back DM loads, dm_rsp_ready=0 for 3 cycles on first rsp ->
//     rsp_valid/rsp_data stable for 3 cycles, no grants, mem_mode=MODE_IDLE;
//     resumes on ready.
//   5 reset=1 in the cycle after an IF read accept -> no if_rsp_valid; next cycle all outputs idle.
//   6 With MEM_ARB_STATS_EN, test 2 for 8 cycles -> dm_forced_yield=2, stall_cycles=8.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single-port word memory
// with 1-cycle read latency. Optional statistics counters are enabled by MEM_ARB_STATS_EN.
`ifndef memModeOut
`define memModeOut 2'b00
`endif
`ifndef memModeIn
`define memModeIn 2'b01
`endif

module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter logic [1:0]  MODE_IDLE    = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [15:0] if_addr,
  output logic        if_rsp_valid,
  output logic [15:0] if_rsp_data,
  input  logic        if_rsp_ready,
  input  logic        dm_req_valid,
  input  logic        dm_req_write,
  output logic        dm_req_ready,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic        dm_rsp_valid,
  output logic [15:0] dm_rsp_data,
  input  logic        dm_rsp_ready,
  output logic [1:0]  mem_mode,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
`ifdef MEM_ARB_STATS_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] dm_forced_yield,
`endif
  input  logic [15:0] mem_rdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;      // 1 = DM owns the outstanding response
  logic [15:0]       hold_q, hold_d;
  logic [CNT_W-1:0]  starve_q, starve_d;

  logic        own_rdy, blocked, force_if, gnt_if, gnt_dm, rd_acc, rsp_on;
  logic [15:0] rsp_data;

  // Grant and memory command
  always_comb begin
    own_rdy  = owner_q ? dm_rsp_ready : if_rsp_ready;
    blocked  = reset || (state_q == S_HOLD) || ((state_q == S_READ) && !own_rdy);
    force_if = (STARVE_LIMIT != 0) && (starve_q == LIMIT_C) && if_req_valid;
    gnt_if   = !blocked && (force_if || (if_req_valid && !dm_req_valid));
    gnt_dm   = !blocked && !force_if && dm_req_valid;
    rd_acc   = gnt_if || (gnt_dm && !dm_req_write);

    if_req_ready = gnt_if;
    dm_req_ready = gnt_dm;
    mem_mode     = MODE_IDLE;
    mem_addr     = 16'h0000;
    mem_wdata    = 16'h0000;
    if (gnt_if) begin
      mem_mode = `memModeOut;
      mem_addr = if_addr;
    end else if (gnt_dm) begin
      mem_mode  = dm_req_write ? `memModeIn : `memModeOut;
      mem_addr  = dm_addr;
      mem_wdata = dm_req_write ? dm_wdata : 16'h0000;
    end
  end

  // Response path
  always_comb begin
    rsp_on       = !reset && (state_q != S_IDLE);
    rsp_data     = (state_q == S_HOLD) ? hold_q : mem_rdata;
    if_rsp_valid = rsp_on && !owner_q;
    dm_rsp_valid = rsp_on && owner_q;
    if_rsp_data  = if_rsp_valid ? rsp_data : 16'h0000;
    dm_rsp_data  = dm_rsp_valid ? rsp_data : 16'h0000;
  end

  // Next state, owner, hold capture and starvation count
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (rd_acc) begin
          state_d = S_READ;
          owner_d = gnt_dm;
        end
      end
      S_READ: begin
        if (own_rdy) begin
          state_d = rd_acc ? S_READ : S_IDLE;
          if (rd_acc) owner_d = gnt_dm;
        end else begin
          state_d = S_HOLD;
          hold_d  = mem_rdata;
        end
      end
      S_HOLD: begin
        if (own_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (gnt_dm && if_req_valid)
      starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + CNT_W'(1);
    else if (gnt_if || !if_req_valid)
      starve_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      hold_q   <= 16'h0000;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_q, yield_q;
  logic        stall_now;

  // A stall is any valid request left unaccepted this cycle
  assign stall_now = (if_req_valid && !gnt_if) || (dm_req_valid && !gnt_dm);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= 16'h0000;
      yield_q <= 16'h0000;
    end else begin
      if (stall_now)          stall_q <= sat_inc(stall_q);
      if (force_if && gnt_if) yield_q <= sat_inc(yield_q);
    end
  end

  assign stall_cycles    = stall_q;
  assign dm_forced_yield = yield_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level reference model.
`ifndef memModeOut
`define memModeOut 2'b00
`endif
`ifndef memModeIn
`define memModeIn 2'b01
`endif

module tb_mem_arbiter;
  localparam int unsigned LIMIT = 3;
  localparam logic [1:0]  IDLE  = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_valid = 1'b0, if_req_ready, if_rsp_valid, if_rsp_ready = 1'b1;
  logic [15:0] if_addr = 16'h0, if_rsp_data;
  logic        dm_req_valid = 1'b0, dm_req_write = 1'b0, dm_req_ready, dm_rsp_valid, dm_rsp_ready = 1'b1;
  logic [15:0] dm_addr = 16'h0, dm_wdata = 16'h0, dm_rsp_data;
  logic [1:0]  mem_mode;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stall_cycles, dm_forced_yield;
`endif

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .MODE_IDLE(IDLE)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_ready(if_rsp_ready),
    .dm_req_valid(dm_req_valid), .dm_req_write(dm_req_write), .dm_req_ready(dm_req_ready),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data), .dm_rsp_ready(dm_rsp_ready),
    .mem_mode(mem_mode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef MEM_ARB_STATS_EN
    .stall_cycles(stall_cycles), .dm_forced_yield(dm_forced_yield),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h1234;
      16'h0100: return 16'h1111;
      16'h0200: return 16'h2222;
      16'h0300: return 16'h3333;
      16'h0301: return 16'h4444;
      default:  return a ^ 16'hA5C3;
    endcase
  endfunction

  // Memory seen by the DUT: registered read, write on edge
  logic [15:0] tbmem [0:65535];
  bit          tbw   [0:65535];
  always @(posedge clk) begin
    if (mem_mode == `memModeOut) mem_rdata <= tbw[mem_addr] ? tbmem[mem_addr] : init_val(mem_addr);
    else if (mem_mode == `memModeIn) begin
      tbmem[mem_addr] <= mem_wdata;
      tbw[mem_addr]   <= 1'b1;
    end
  end

  // Reference model state
  logic [15:0] refmem [0:65535];
  bit          refw   [0:65535];
  bit          m_pend, m_own, m_seen;
  logic [15:0] m_data;
  int unsigned m_streak, m_stall, m_yield;

  int total = 0, bad = 0;
  logic        a_if_rdy, a_dm_rdy, a_if_rv, a_dm_rv;
  logic [1:0]  a_mode;
  logic [15:0] a_addr, a_wdata, a_if_rd, a_dm_rd, a_stall, a_yield;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return refw[a] ? refmem[a] : init_val(a);
  endfunction

  task automatic cyc(input logic rs, input logic ifv, input logic [15:0] ifa, input logic ifrr,
                     input logic dmv, input logic dmw, input logic [15:0] dma,
                     input logic [15:0] dmwd, input logic dmrr);
    int g;
    bit forced, allow, ordy;
    logic e_ifr, e_dmr, e_ifv, e_dmv;
    logic [1:0] e_mode;
    logic [15:0] e_addr, e_wd, e_ifd, e_dmd;
    @(negedge clk);
    reset = rs; if_req_valid = ifv; if_addr = ifa; if_rsp_ready = ifrr;
    dm_req_valid = dmv; dm_req_write = dmw; dm_addr = dma; dm_wdata = dmwd; dm_rsp_ready = dmrr;
    #1;
    a_if_rdy = if_req_ready; a_dm_rdy = dm_req_ready; a_mode = mem_mode; a_addr = mem_addr;
    a_wdata = mem_wdata; a_if_rv = if_rsp_valid; a_if_rd = if_rsp_data;
    a_dm_rv = dm_rsp_valid; a_dm_rd = dm_rsp_data;
`ifdef MEM_ARB_STATS_EN
    a_stall = stall_cycles; a_yield = dm_forced_yield;
`else
    a_stall = 16'h0; a_yield = 16'h0;
`endif
    // Expected behaviour from the arbitration rules
    g = 0; e_ifv = 0; e_dmv = 0; e_ifd = 0; e_dmd = 0;
    ordy = m_own ? dmrr : ifrr;
    allow = !rs && (!m_pend || (!m_seen && ordy));
    forced = (LIMIT != 0) && (m_streak == LIMIT) && ifv;
    if (allow) begin
      if (forced) g = 1;
      else if (dmv) g = 2;
      else if (ifv) g = 1;
    end
    if (!rs && m_pend) begin
      if (m_own) begin e_dmv = 1; e_dmd = m_data; end
      else begin e_ifv = 1; e_ifd = m_data; end
    end
    e_ifr = (g == 1); e_dmr = (g == 2);
    e_mode = IDLE; e_addr = 0; e_wd = 0;
    if (g == 1) begin e_mode = `memModeOut; e_addr = ifa; end
    if (g == 2) begin e_mode = dmw ? `memModeIn : `memModeOut; e_addr = dma; e_wd = dmw ? dmwd : 16'h0; end
    chk("if_req_ready", {15'h0, a_if_rdy}, {15'h0, e_ifr});
    chk("dm_req_ready", {15'h0, a_dm_rdy}, {15'h0, e_dmr});
    chk("mem_mode", {14'h0, a_mode}, {14'h0, e_mode});
    chk("mem_addr", a_addr, e_addr);
    chk("mem_wdata", a_wdata, e_wd);
    chk("if_rsp_valid", {15'h0, a_if_rv}, {15'h0, e_ifv});
    chk("if_rsp_data", a_if_rd, e_ifd);
    chk("dm_rsp_valid", {15'h0, a_dm_rv}, {15'h0, e_dmv});
    chk("dm_rsp_data", a_dm_rd, e_dmd);
`ifdef MEM_ARB_STATS_EN
    chk("stall_cycles", a_stall, m_stall[15:0]);
    chk("dm_forced_yield", a_yield, m_yield[15:0]);
`endif
    // Advance model across the clock edge
    if (rs) begin
      m_pend = 0; m_seen = 0; m_streak = 0; m_stall = 0; m_yield = 0;
    end else begin
      if ((ifv && g != 1) || (dmv && g != 2)) m_stall = (m_stall == 16'hFFFF) ? m_stall : m_stall + 1;
      if (g == 1 && forced) m_yield = (m_yield == 16'hFFFF) ? m_yield : m_yield + 1;
      if (m_pend) begin
        if (ordy) m_pend = 0;
        else m_seen = 1;
      end
      if (g == 1 || (g == 2 && !dmw)) begin
        m_pend = 1; m_seen = 0; m_own = (g == 2);
        m_data = ref_rd(g == 1 ? ifa : dma);
      end
      if (g == 2 && dmw) begin refmem[dma] = dmwd; refw[dma] = 1; end
      if (g == 2 && ifv) m_streak = (m_streak >= LIMIT) ? LIMIT : m_streak + 1;
      else if (g == 1 || !ifv) m_streak = 0;
    end
  endtask

  typedef struct {
    logic ifv; logic [15:0] ifa; logic dmv; logic dmw; logic [15:0] dma; logic [15:0] dmwd;
    logic e_ifr; logic e_dmr; logic [1:0] e_mode; logic e_dmrv; logic [15:0] e_dmrd;
  } vec_t;
  vec_t tbl [11];

  initial begin
    m_pend = 0; m_own = 0; m_seen = 0; m_data = 0; m_streak = 0; m_stall = 0; m_yield = 0;
    for (int i = 0; i < 8; i++) begin
      bit d;
      d = (i % 4) != 3;
      tbl[i] = '{1'b1, 16'h0100, 1'b1, 1'b0, 16'h0200, 16'h0, !d, d,
                 `memModeOut, (i % 4) != 0, ((i % 4) != 0) ? 16'h2222 : 16'h0};
    end
    tbl[8]  = '{1'b0, 16'h0, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1'b0, 1'b1, `memModeIn, 1'b0, 16'h0};
    tbl[9]  = '{1'b0, 16'h0, 1'b1, 1'b0, 16'hFFFF, 16'h0, 1'b0, 1'b1, `memModeOut, 1'b0, 16'h0};
    tbl[10] = '{1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, IDLE, 1'b1, 16'hBEEF};

    // Reset state
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 1);

    // Single fetch read
    cyc(0, 1, 16'h0010, 1, 0, 0, 0, 0, 1);
    chk("t1_mode", {14'h0, a_mode}, {14'h0, `memModeOut});
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("t1_if_rsp_valid", {15'h0, a_if_rv}, 16'h1);
    chk("t1_if_rsp_data", a_if_rd, 16'h1234);

    // Starvation pattern, then store/load at the top address
    for (int i = 0; i < 11; i++) begin
      cyc(0, tbl[i].ifv, tbl[i].ifa, 1, tbl[i].dmv, tbl[i].dmw, tbl[i].dma, tbl[i].dmwd, 1);
      chk($sformatf("tbl%0d_if_rdy", i), {15'h0, a_if_rdy}, {15'h0, tbl[i].e_ifr});
      chk($sformatf("tbl%0d_dm_rdy", i), {15'h0, a_dm_rdy}, {15'h0, tbl[i].e_dmr});
      chk($sformatf("tbl%0d_mode", i), {14'h0, a_mode}, {14'h0, tbl[i].e_mode});
      chk($sformatf("tbl%0d_dm_rv", i), {15'h0, a_dm_rv}, {15'h0, tbl[i].e_dmrv});
      chk($sformatf("tbl%0d_dm_rd", i), a_dm_rd, tbl[i].e_dmrd);
    end

    // Consumer stall on back-to-back loads
    cyc(0, 0, 0, 1, 1, 0, 16'h0300, 0, 1);
    chk("t4_accept_a", {15'h0, a_dm_rdy}, 16'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 1, 0, 16'h0301, 0, 0);
      chk("t4_hold_valid", {15'h0, a_dm_rv}, 16'h1);
      chk("t4_hold_data", a_dm_rd, 16'h3333);
      chk("t4_hold_nogrant", {15'h0, a_dm_rdy}, 16'h0);
      chk("t4_hold_idle", {14'h0, a_mode}, {14'h0, IDLE});
    end
    cyc(0, 0, 0, 1, 1, 0, 16'h0301, 0, 1);
    chk("t4_retire_data", a_dm_rd, 16'h3333);
    chk("t4_retire_nogrant", {15'h0, a_dm_rdy}, 16'h0);
    cyc(0, 0, 0, 1, 1, 0, 16'h0301, 0, 1);
    chk("t4_accept_b", {15'h0, a_dm_rdy}, 16'h1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("t4_rsp_b", a_dm_rd, 16'h4444);

    // Reset while a fetch read is pending
    cyc(0, 1, 16'h0010, 1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("t5_no_rsp", {15'h0, a_if_rv}, 16'h0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("t5_idle_rv", {14'h0, a_if_rv, a_dm_rv}, 16'h0);
    chk("t5_idle_mode", {14'h0, a_mode}, {14'h0, IDLE});

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ia, da;
      ia = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      da = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      cyc($urandom_range(0, 63) == 0, 1'($urandom), ia, $urandom_range(0, 3) != 0,
          1'($urandom), 1'($urandom), da, 16'($urandom), $urandom_range(0, 3) != 0);
    end

`ifdef MEM_ARB_STATS_EN
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(0, 1, 16'h0100, 1, 1, 0, 16'h0200, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1);
    chk("t6_yield", a_yield, 16'd2);
    chk("t6_stall", a_stall, 16'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
